// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder, one bit per cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             LT_s,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    localparam logic [1:0] IterMul  = 2'd0;
    localparam logic [1:0] IterDivu = 2'd1;
    localparam logic [1:0] IterRemu = 2'd2;

    logic             state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       iter_q, iter_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             z_q, z_d;
    logic             lt_q, lt_d;
    logic             lt_pend_q, lt_pend_d;
    logic             out_valid_q, out_valid_d;

    logic             is_iter;
    logic [1:0]       iter_sel;
    logic [WIDTH-1:0] simple_y;
    logic [SHW-1:0]   shamt;
    logic             operands_lt;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] step_a, step_b, step_acc;
    logic [WIDTH-1:0] iter_result;

    assign shamt       = B[SHW-1:0];
    assign operands_lt = $signed(A) < $signed(B);

    // Decode of the op presented at the input; undefined encodings yield zero.
    always_comb begin
        is_iter  = 1'b0;
        iter_sel = IterMul;
        simple_y = '0;
        case (opcode)
            4'b0000: begin
                case (funct3)
                    3'b000: simple_y = A + B;
                    3'b001: simple_y = A - B;
                    3'b010: begin
                        is_iter  = 1'b1;
                        iter_sel = IterMul;
                    end
                    3'b011: begin
                        is_iter  = 1'b1;
                        iter_sel = IterDivu;
                    end
                    3'b100: begin
                        is_iter  = 1'b1;
                        iter_sel = IterRemu;
                    end
                    default: simple_y = '0;
                endcase
            end
            4'b0001: begin
                case (funct3)
                    3'b000:  simple_y = A & B;
                    3'b001:  simple_y = A | B;
                    3'b010:  simple_y = A ^ B;
                    3'b011:  simple_y = ~A;
                    3'b100:  simple_y = A << shamt;
                    3'b101:  simple_y = A >> shamt;
                    3'b110:  simple_y = $signed(A) >>> shamt;
                    default: simple_y = '0;
                endcase
            end
            4'b0100, 4'b0111, 4'b1000: simple_y = A + B;
            4'b0101: simple_y = A & B;
            4'b0110: simple_y = A | B;
            default: simple_y = '0;
        endcase
    end

    // One iteration step. a_q: multiplicand / dividend-then-quotient,
    // b_q: multiplier / divisor, acc_q: product / partial remainder.
    assign rem_shift = {acc_q, a_q[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};

    always_comb begin
        step_a   = a_q;
        step_b   = b_q;
        step_acc = acc_q;
        if (iter_q == IterMul) begin
            if (b_q[0]) begin
                step_acc = acc_q + a_q;
            end
            step_a = a_q << 1;
            step_b = b_q >> 1;
        end else if (rem_shift >= {1'b0, b_q}) begin
            step_acc = rem_diff[WIDTH-1:0];
            step_a   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
            step_acc = rem_shift[WIDTH-1:0];
            step_a   = {a_q[WIDTH-2:0], 1'b0};
        end
    end

    assign iter_result = (iter_q == IterDivu) ? step_a : step_acc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        iter_d      = iter_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        y_d         = y_q;
        z_d         = z_q;
        lt_d        = lt_q;
        lt_pend_d   = lt_pend_q;
        out_valid_d = 1'b0;
        if (state_q == StIdle) begin
            if (in_valid) begin
                if (is_iter) begin
                    state_d   = StRun;
                    cnt_d     = CW'(WIDTH);
                    iter_d    = iter_sel;
                    a_d       = A;
                    b_d       = B;
                    acc_d     = '0;
                    lt_pend_d = operands_lt;
                end else begin
                    y_d         = simple_y;
                    z_d         = (simple_y == '0);
                    lt_d        = operands_lt;
                    out_valid_d = 1'b1;
                end
            end
        end else begin
            a_d   = step_a;
            b_d   = step_b;
            acc_d = step_acc;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d     = StIdle;
                y_d         = iter_result;
                z_d         = (iter_result == '0);
                lt_d        = lt_pend_q;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            iter_q      <= IterMul;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            z_q         <= 1'b0;
            lt_q        <= 1'b0;
            lt_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            iter_q      <= iter_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            z_q         <= z_d;
            lt_q        <= lt_d;
            lt_pend_q   <= lt_pend_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = ~in_ready;
    assign out_valid = out_valid_q;
    assign Y         = y_q;
    assign Z         = z_q;
    assign LT_s      = lt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected results (value and
// completion cycle) from an arithmetic reference model; a monitor pops on out_valid.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [2:0]  funct3;
    logic [15:0] a, b;
    logic        out_valid;
    logic [15:0] y;
    logic        z, lt_s, busy;

    logic        v32, rdy32, ov32, z32, lt32, busy32;
    logic [31:0] a32, b32, y32;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] y;
        logic        z;
        logic        lt;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    alu_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .funct3   (funct3),
        .A        (a),
        .B        (b),
        .out_valid(out_valid),
        .Y        (y),
        .Z        (z),
        .LT_s     (lt_s),
        .busy     (busy)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (v32),
        .in_ready (rdy32),
        .opcode   (4'b0000),
        .funct3   (3'b010),
        .A        (a32),
        .B        (b32),
        .out_valid(ov32),
        .Y        (y32),
        .Z        (z32),
        .LT_s     (lt32),
        .busy     (busy32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic from the op definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [2:0] f3,
                                   input logic [15:0] x, input logic [15:0] w);
        exp_t e;
        int   s;
        s     = w % 16;
        e.y   = 16'h0;
        e.lat = 0;
        e.cyc = 0;
        case (op)
            4'd0: case (f3)
                3'd0: e.y = x + w;
                3'd1: e.y = x - w;
                3'd2: begin e.y = 16'((32'(x) * 32'(w)) % 65536); e.lat = 16; end
                3'd3: begin e.y = (w == 0) ? 16'hFFFF : x / w; e.lat = 16; end
                3'd4: begin e.y = (w == 0) ? x : x % w; e.lat = 16; end
                default: e.y = 16'h0;
            endcase
            4'd1: case (f3)
                3'd0: e.y = x & w;
                3'd1: e.y = x | w;
                3'd2: e.y = x ^ w;
                3'd3: e.y = ~x;
                3'd4: e.y = 16'((32'(x) << s) % 65536);
                3'd5: e.y = x / 16'(1 << s);
                3'd6: e.y = 16'($signed(32'($signed(x))) / $signed(32'(1 << s))
                             - ((x[15] && (x % 16'(1 << s)) != 0) ? 1 : 0));
                default: e.y = 16'h0;
            endcase
            4'd4, 4'd7, 4'd8: e.y = x + w;
            4'd5: e.y = x & w;
            4'd6: e.y = x | w;
            default: e.y = 16'h0;
        endcase
        e.z  = (e.y == 16'h0);
        e.lt = $signed(x) < $signed(w);
        return e;
    endfunction

    // Drives one op; called #1 after an edge, returns #1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [2:0] f3, input logic [15:0] x,
                         input logic [15:0] w, input bit use_exp, input logic [15:0] exp_y);
        exp_t e;
        int   waited = 0;
        e = model(op, f3, x, w);
        if (use_exp) begin
            e.y = exp_y;
            e.z = (exp_y == 16'h0);
        end
        opcode   = op;
        funct3   = f3;
        a        = x;
        b        = w;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            e.cyc = cyc + 1 + e.lat;
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("Y", 32'(y), 32'(e.y));
                check("Z", 32'(z), 32'(e.z));
                check("LT_s", 32'(lt_s), 32'(e.lt));
                check("result_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops[$];
        logic [2:0] fs[$];
        int         n_busy;
        int         lat;
        logic [15:0] rb;
        int          k;

        rst = 1'b1; in_valid = 1'b1; opcode = 4'd0; funct3 = 3'd0; a = 16'h1; b = 16'h1;
        v32 = 1'b0; a32 = '0; b32 = '0;
        // Reset held together with a valid ADD request: reset wins.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_Y", 32'(y), 32'd0);
        check("rst_Z", 32'(z), 32'd0);
        check("rst_LT_s", 32'(lt_s), 32'd0);

        // Back-to-back simple ops.
        issue(4'd0, 3'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000);
        issue(4'd0, 3'd1, 16'h0005, 16'h0005, 1'b1, 16'h0000);
        drain();

        // MUL with a mid-run request that must be ignored.
        issue(4'd0, 3'd2, 16'h0123, 16'h0010, 1'b1, 16'h1230);
        n_busy = 0;
        for (int i = 0; i < 16; i++) begin
            if (!in_ready && busy) n_busy++;
            if (i == 4) begin
                in_valid = 1'b1; opcode = 4'd0; funct3 = 3'd0; a = 16'h1; b = 16'h1;
            end
            if (i == 5) in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check("mul_busy_cycles", 32'(n_busy), 32'd16);
        check("mul_ready_after", 32'(in_ready), 32'd1);
        drain();

        issue(4'd0, 3'd3, 16'd100, 16'd7, 1'b1, 16'd14);
        issue(4'd0, 3'd4, 16'd100, 16'd7, 1'b1, 16'd2);
        issue(4'd0, 3'd3, 16'h1234, 16'h0000, 1'b1, 16'hFFFF);
        issue(4'd0, 3'd4, 16'h1234, 16'h0000, 1'b1, 16'h1234);
        issue(4'd1, 3'd6, 16'h8000, 16'h0004, 1'b1, 16'hF800);
        issue(4'd1, 3'd5, 16'h8000, 16'h0004, 1'b1, 16'h0800);
        issue(4'd1, 3'd4, 16'h0001, 16'h0013, 1'b1, 16'h0008);
        issue(4'd2, 3'd0, 16'h1234, 16'h1111, 1'b1, 16'h0000);
        issue(4'd15, 3'd7, 16'h8000, 16'h0004, 1'b1, 16'h0000);
        drain();

        // Reset in the middle of a DIVU: in-flight op must vanish.
        issue(4'd0, 3'd3, 16'd5000, 16'd3, 1'b0, 16'h0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_Y", 32'(y), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        repeat (30) @(posedge clk);
        #1;

        // Randomized mix including undefined encodings.
        ops = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
                4'd1, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd3, 4'd12};
        fs  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                3'd6, 3'd7, 3'd5, 3'd2, 3'd1, 3'd0, 3'd3, 3'd0, 3'd4};
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, ops.size() - 1);
            case ($urandom_range(0, 3))
                0:       rb = 16'h0;
                1:       rb = 16'($urandom_range(1, 20));
                default: rb = 16'($urandom);
            endcase
            issue(ops[k], fs[k], 16'($urandom), rb, 1'b0, 16'h0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // WIDTH=32 multiply latency.
        a32 = 32'h0001_2345; b32 = 32'h0000_0100; v32 = 1'b1;
        check("w32_ready", 32'(rdy32), 32'd1);
        @(posedge clk);
        #1;
        v32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("w32_latency", 32'(lat), 32'd32);
        check("w32_Y", y32, 32'h0123_4500);
        check("w32_Z", 32'(z32), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the CPU's combinational ALU. It sits in the execute stage of `cpu_top` and accepts one operation per handshake. The opcode/funct3 decode covers the existing ISA ops plus new R-type MUL, DIVU, REMU and SRA. Simple ops complete in 1 cycle; MUL/DIV/REM run an iterative datapath for WIDTH cycles. Results and flags are registered and held until the next result.

## Interface
- `WIDTH`, default 16: datapath width; must be ≥ 4 and a power of 2.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived; do not override).
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operation request.
- `in_ready` output, 1 bit: unit can accept; an op is accepted on an edge where `in_valid & in_ready`.
- `opcode` input, 4 bits: instr[15:12].
- `funct3` input, 3 bits: instr[2:0]; used for opcodes 0000 and 0001 only.
- `A` input, WIDTH bits: Rs operand.
- `B` input, WIDTH bits: Rt operand or immediate.
- `out_valid` output, 1 bit: one-cycle pulse marking a new result.
- `Y` output, WIDTH bits: result, held until the next result.
- `Z` output, 1 bit: `Y == 0`, registered with `Y`.
- `LT_s` output, 1 bit: signed `A < B` of the accepted operands, registered with `Y`.
- `busy` output, 1 bit: iterative op in progress; equals `~in_ready`.

## Operation
- `A`, `B`, `opcode` and `funct3` are captured at accept. Inputs are ignored at any other time.
- Single-cycle ops:
  - 0000/000 ADD; 0000/001 SUB.
  - 0001/000 AND, 001 OR, 010 XOR, 011 NOT A, 100 SLL, 101 SRL.
  - 0100 ADDI, 0111 LD and 1000 ST: A+B. 0101 ANDI: A&B. 0110 ORI: A|B.
  - 0001/110 SRA: arithmetic right shift.
  - All shifts use amount `B[SHW-1:0]`.
  - Every other opcode/funct3 combination (including 0010–0011 and 1001–1111) yields Y=0, Z=1, and still completes with an `out_valid` pulse.
- Iterative ops:
  - 0000/010 MUL: low WIDTH bits of A*B, unsigned shift-add, one bit per cycle.
  - 0000/011 DIVU: unsigned quotient, restoring division, one bit per cycle.
  - 0000/100 REMU: unsigned remainder, same datapath as DIVU.
  - Divide by zero: DIVU gives all-ones; REMU gives A. Takes the full iterative latency, no early exit.
- Arithmetic wraps modulo 2^WIDTH; no carry or overflow output.
- FSM states:
  - IDLE: `in_ready`=1. An accept of a simple op registers the result, pulses `out_valid`, and stays in IDLE. An accept of an iterative op loads the operands and sets cnt=WIDTH, then goes to RUN.
  - RUN: `in_ready`=0. Each edge performs one step and decrements cnt. On the edge where cnt==1, the result is registered, `out_valid` pulses, and the FSM returns to IDLE.
- `in_valid` while in RUN is ignored; the requester must hold or reissue it.
- Reset values: state=IDLE, `in_ready`=1, `busy`=0, `out_valid`=0, Y=0, Z=0, LT_s=0, cnt=0, and all internal accumulators are 0.

## Timing
- Accept edge = edge 0.
- Simple op: `out_valid`=1 in the cycle after edge 0; Y, Z and LT_s are valid in that same cycle.
- Iterative op:
  - `in_ready`=0 from after edge 0 until edge WIDTH.
  - `out_valid`=1 after edge WIDTH, so latency is WIDTH cycles (16 at default).
  - `in_ready` returns to 1 in the same cycle as `out_valid`.
- Back-to-back simple ops sustain 1 op/cycle, with `out_valid` high on consecutive cycles.
- A new op may be accepted in the cycle `out_valid` is high. The held result is then replaced at the next result edge.
- `rst` asserted mid-RUN: on the next edge the FSM goes to IDLE, outputs take their reset values, and the in-flight op never produces `out_valid`.
- `rst` together with `in_valid`: reset wins and the op is not accepted.

## Test plan
- Reset: hold `rst` for 2 cycles -> `in_ready`=1, `out_valid`=0, Y=0x0000, Z=0, LT_s=0.
- ADD 0x7FFF+0x0001 -> next cycle `out_valid`=1, Y=0x8000, Z=0, LT_s=0. Then SUB 0x0005-0x0005 on the immediately following cycle -> Y=0, Z=1.
- MUL 0x0123*0x0010 -> Y=0x1230 exactly 16 cycles after accept. `in_ready`=0 for 16 cycles. An `in_valid` pulse mid-run is ignored and produces no extra `out_valid`.
- Divide cases:
  - DIVU 100/7 -> Y=14.
  - REMU 100/7 -> Y=2.
  - DIVU 0x1234/0 -> Y=0xFFFF.
  - REMU 0x1234/0 -> Y=0x1234.
  - Each returns after 16 cycles.
- Shifts with B=4:
  - SRA 0x8000 -> 0xF800; SRL 0x8000 -> 0x0800.
  - SLL 0x0001 with B=0x0013 -> 0x0008 (amount 3).
  - LT_s for A=0x8000, B=0x0004 -> 1.
- Reset mid-op: assert `rst` at cycle 5 of a DIVU -> `in_ready`=1 and Y=0 on the next cycle, and no `out_valid` ever follows. Repeat the MUL test at WIDTH=32 -> latency 32 cycles.
